// File: rtl/reg_scanner_pkg.sv
// Shared definitions for the register scanner: scan FSM state encoding,
// register index width and a helper to size the dwell counter.
package reg_scanner_pkg;

    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] regIdx_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DONE    = 3'd4
    } scanState_t;

    // Bits needed to count 0..depth-1, never less than one bit.
    function automatic int counterWidth(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_scanner_dwell.sv
// Dwell timer for the scanner: counts cycles while a captured value is on
// display and flags the last cycle of the dwell period.
module dwell_counter
    import reg_scanner_pkg::*;
#(
    parameter int DWELL = 50000000
)
(
    input  logic clock_in,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int CNT_W = counterWidth(DWELL);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles, wrap after the terminal value, clear on request.
    always_ff @(posedge clock_in) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= (r_count == LAST_COUNT) ? '0 : r_count + CNT_W'(1);
        end
    end

    assign o_terminal = (r_count == LAST_COUNT);

endmodule

// File: rtl/reg_scanner.sv
// Register-file scanner: walks indices 0..NUM_REGS-1, captures each read
// value and shows it for DWELL cycles (auto) or until a step pulse (manual).
module reg_scanner
    import reg_scanner_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DWELL    = 50000000
)
(
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 step,
    input  logic [31:0]          readData,
    output logic [REG_IDX_W-1:0] readReg,
    output logic [31:0]          shownData,
    output logic [REG_IDX_W-1:0] shownIdx,
    output logic                 valid,
    output logic                 busy,
    output logic                 done
);

    localparam regIdx_t LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

    scanState_t r_state;
    scanState_t w_nextState;
    regIdx_t    r_index;
    logic [31:0] r_shownData;
    regIdx_t    r_shownIdx;
    logic       r_valid;
    logic       r_busy;
    logic       r_done;

    logic w_accept;
    logic w_capture;
    logic w_advance;
    logic w_lastIdx;
    logic w_dwellClear;
    logic w_dwellEnable;
    logic w_dwellTerminal;
    logic w_busyNext;
    logic w_doneNext;

    dwell_counter #(
        .DWELL(DWELL)
    ) u_dwell (
        .clock_in  (clock_in),
        .reset     (reset),
        .i_clear   (w_dwellClear),
        .i_enable  (w_dwellEnable),
        .o_terminal(w_dwellTerminal)
    );

    assign w_lastIdx = (r_index == LAST_IDX);

    // State register; reset aborts any scan in progress.
    always_ff @(posedge clock_in) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode for the scan sequence.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_nextState = ST_ADDR;
            ST_ADDR:    w_nextState = ST_CAPTURE;
            ST_CAPTURE: w_nextState = ST_HOLD;
            ST_HOLD:    if (w_advance) w_nextState = w_lastIdx ? ST_DONE : ST_ADDR;
            ST_DONE:    w_nextState = ST_IDLE;
            default:    w_nextState = ST_IDLE;
        endcase
    end

    // Control strobes and next values of the registered status outputs.
    always_comb begin
        w_accept      = (r_state == ST_IDLE) && start;
        w_capture     = (r_state == ST_CAPTURE);
        w_advance     = (r_state == ST_HOLD) && (step_mode ? step : w_dwellTerminal);
        w_dwellClear  = (r_state == ST_CAPTURE);
        w_dwellEnable = (r_state == ST_HOLD) && !step_mode;
        w_busyNext    = (w_nextState != ST_IDLE);
        w_doneNext    = (w_nextState == ST_DONE);
    end

    // Scan index: cleared on a new scan, bumped on advance, never past the last entry.
    always_ff @(posedge clock_in) begin
        if (!reset) begin
            r_index <= '0;
        end else if (w_accept) begin
            r_index <= '0;
        end else if (w_advance && !w_lastIdx) begin
            r_index <= r_index + REG_IDX_W'(1);
        end
    end

    // Registered outputs; the last capture is kept after the scan ends.
    always_ff @(posedge clock_in) begin
        if (!reset) begin
            r_shownData <= '0;
            r_shownIdx  <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= w_busyNext;
            r_done <= w_doneNext;
            if (w_capture) begin
                r_shownData <= readData;
                r_shownIdx  <= r_index;
                r_valid     <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign readReg   = r_index;
    assign shownData = r_shownData;
    assign shownIdx  = r_shownIdx;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/reg_scanner.md
REG_SCANNER -- requirements
Module: reg_scanner

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of register-file entries scanned (index 0..NUM_REGS-1, NUM_REGS <= 32).
REQ-002 SHALL have parameter DWELL, default 50000000, clock cycles each captured value is held in auto mode (DWELL >= 1).
REQ-003 SHALL have port clock_in, input, 1, system clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous, active-low.
REQ-005 SHALL have port start, input, 1, level-sampled request to begin a scan; accepted only in IDLE.
REQ-006 SHALL have port step_mode, input, 1, 1 = manual advance by step, 0 = auto advance after DWELL.
REQ-007 SHALL have port step, input, 1, single-cycle advance pulse, honoured only in HOLD with step_mode=1.
REQ-008 SHALL have port readData, input, 32, combinational read data returned by the register file for readReg.
REQ-009 SHALL have port readReg, output, 5, register index driven to the register file read port.
REQ-010 SHALL have port shownData, output, 32, last captured register value.
REQ-011 SHALL have port shownIdx, output, 5, index of the value in shownData.
REQ-012 SHALL have port valid, output, 1, high while shownData/shownIdx hold a capture of the current scan.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when the scan completes.

Function
REQ-015 SHALL implement states IDLE, ADDR, CAPTURE, HOLD, DONE.
REQ-016 IDLE -> ADDR on start=1; internal index cleared to 0; readReg=index in every state.
REQ-017 ADDR SHALL last exactly one cycle (read-path settle), then CAPTURE.
REQ-018 CAPTURE SHALL latch readData into shownData and index into shownIdx, set valid, clear dwell counter, then HOLD; capture-to-output latency 1 cycle.
REQ-019 HOLD, auto mode: dwell counter increments each cycle; at count DWELL-1 advance.
REQ-020 HOLD, manual mode: advance on the cycle step=1; step in any other state SHALL be ignored.
REQ-021 Advance: if index = NUM_REGS-1 go to DONE, else index+1 and go to ADDR.
REQ-022 DONE SHALL last one cycle with done=1, then IDLE; shownData/shownIdx/valid retained in IDLE until next start.
REQ-023 start SHALL be ignored while busy; start held high through DONE begins a new scan from IDLE on the next cycle.
REQ-024 Changing step_mode during HOLD SHALL take effect next cycle; switching to auto does not reset the dwell counter.
REQ-025 A register-file write to the scanned index is reflected only if present on readData at the CAPTURE edge; no other coherency guarantee.
REQ-026 Index SHALL never exceed NUM_REGS-1; no wrap within a scan.

Reset
REQ-027 With reset=0 at a rising edge: state IDLE, index 0, readReg 0, shownData 0, shownIdx 0, valid 0, busy 0, done 0, dwell counter 0.
REQ-028 Reset mid-scan SHALL abort immediately with no done pulse.
REQ-029 reset is independent of the register file's own reset polarity; top level handles inversion.

Structure
REQ-030 State encoding constants and the 5-bit register index width SHALL live in the shared CPU package.
REQ-031 The dwell counter SHALL be one sub-module, dwell_counter (clear, enable, terminal-count output, width from DWELL).
REQ-032 All outputs SHALL be registered except readReg, which is decoded from the index register.

Verification (bench models register file with regFile[i]=i, combinational read)
REQ-033 Auto, DWELL=4, start pulse: shownIdx/shownData 0..7 each held 4 cycles, captures 6 cycles apart, done pulses once at end, busy low after.
REQ-034 Manual, step pulses on cycles 10,20,30 in HOLD: exactly indices 0,1,2,3 captured; no advance without step; step during ADDR ignored.
REQ-035 Reset=0 asserted during HOLD at index 3: next cycle all outputs zero, no done pulse; fresh start rescans from 0.
REQ-036 Write 0xDEADBEEF to reg 5 before its CAPTURE edge: shownData=0xDEADBEEF at shownIdx=5.
REQ-037 start held high continuously: back-to-back scans, one IDLE cycle between done and next ADDR.
REQ-038 NUM_REGS=1, DWELL=1: start -> ADDR, CAPTURE, HOLD, DONE in 4 consecutive cycles, shownData=0.
